// File: rtl/sha256_msg_sender.sv
// Host-side SHA-256 feeder: packs bytes into 64-bit words for the core
// and serializes the returned 256-bit digest into OUT_W-bit beats.
module sha256_msg_sender #(
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_empty,
  output logic              in_ready,
  output logic [63:0]       data_out,
  output logic              data_valid,
  input  logic              ready_rcv,
  output logic              last_block,
  output logic [6:0]        last_block_invalid_bits,
  input  logic [255:0]      hash,
  input  logic              hash_valid,
  output logic              ready_send,
  output logic [OUT_W-1:0]  digest_out,
  output logic              digest_valid,
  output logic              digest_last,
  input  logic              digest_ready,
  output logic              busy
);

  localparam int N_OUT = 256 / OUT_W;
  localparam int IW = $clog2(N_OUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_OUT - 1);

  typedef enum logic [1:0] {
    PACK,
    SEND,
    WAIT_DIGEST
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d, cnt_n;
  logic [63:0]   word_q, word_d;
  logic          last_q, last_d;
  logic [6:0]    inv_q, inv_d;
  logic [5:0]    lane;

  logic [255:0]  buf_q;
  logic          full_q;
  logic [IW-1:0] idx_q;
  logic          cap, beat;

  assign cnt_n = cnt_q + 4'd1;
  assign lane  = {3'd7 - cnt_q[2:0], 3'b000};

  assign data_out   = word_q;
  assign data_valid = (state_q == SEND);
  assign last_block = last_q;
  assign last_block_invalid_bits = inv_q;
  assign busy = (state_q != PACK) || (cnt_q != 4'd0);

  assign ready_send   = !full_q;
  assign cap          = hash_valid && ready_send;
  assign beat         = full_q && digest_ready;
  assign digest_valid = full_q;
  assign digest_out   = buf_q[255 -: OUT_W];
  assign digest_last  = full_q && (idx_q == LAST_IDX);

  // Ingress next-state: byte packing, word hand-off, digest wait
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    last_d   = last_q;
    inv_d    = inv_q;
    in_ready = 1'b0;
    unique case (state_q)
      PACK: begin
        in_ready = 1'b1;
        if (in_valid && !in_empty) begin
          word_d[lane +: 8] = in_data;
          cnt_d = cnt_n;
          if (in_last) begin
            state_d = SEND;
            last_d  = 1'b1;
            inv_d   = 7'd64 - {cnt_n, 3'b000};
          end else if (cnt_n == 4'd8) begin
            state_d = SEND;
          end
        end else if (in_valid && in_last) begin
          state_d = SEND;
          last_d  = 1'b1;
          inv_d   = 7'd64 - {cnt_q, 3'b000};
        end
      end
      SEND: begin
        if (ready_rcv) begin
          cnt_d   = 4'd0;
          word_d  = 64'd0;
          last_d  = 1'b0;
          inv_d   = 7'd0;
          state_d = last_q ? WAIT_DIGEST : PACK;
        end
      end
      WAIT_DIGEST: begin
        if (cap) state_d = PACK;
      end
      default: state_d = PACK;
    endcase
  end

  // Ingress state and word registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= PACK;
      cnt_q   <= 4'd0;
      word_q  <= 64'd0;
      last_q  <= 1'b0;
      inv_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      last_q  <= last_d;
      inv_q   <= inv_d;
    end
  end

  // Digest capture and MSW-first shift-out
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buf_q  <= 256'd0;
      full_q <= 1'b0;
      idx_q  <= '0;
    end else if (cap) begin
      buf_q  <= hash;
      full_q <= 1'b1;
      idx_q  <= '0;
    end else if (beat) begin
      buf_q <= buf_q << OUT_W;
      idx_q <= idx_q + 1'b1;
      if (idx_q == LAST_IDX) full_q <= 1'b0;
    end
  end

endmodule
